instr_fifo: RTL and testbench

- Parametrised instruction FIFO that replaces the hardcoded per-unit instruction queues.
- One instance per execution unit (DMA, arithmetic, cache).
- Write side accepts up to 4 instructions per cycle from the decoder; read side pops one instruction per cycle into the unit.
- Registered read data; an idle or bubble cycle presents all-zero data, so the instruction's active bit reads 0.

---
 rtl/instr_fifo_if.sv | 32 +++
 rtl/instr_fifo.sv | 105 ++++++++++
 tb/tb_instr_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fifo_if.sv
// Bus bundle for instr_fifo: decoder push side, unit pop side and status flags.
// Handshake: a push (we) or pop (re) takes effect on the clock edge where it is high; there is no ready.
// A push is all-or-nothing and is dropped if it does not fit. A pop on an empty FIFO returns zero data.
interface instr_fifo_if #(
    parameter int LINE  = 22,
    parameter int DEPTH = 32
);
    logic                     re;
    logic                     we;
    logic [1:0]               we_count;
    logic [LINE-1:0]          dat_w_1;
    logic [LINE-1:0]          dat_w_2;
    logic [LINE-1:0]          dat_w_3;
    logic [LINE-1:0]          dat_w_4;
    logic [LINE-1:0]          dat_r;
    logic [$clog2(DEPTH):0]   count;
    logic                     full_soon;
    logic                     empty_soon;
    logic                     empty;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output re, we, we_count, dat_w_1, dat_w_2, dat_w_3, dat_w_4,
        input  dat_r, count, full_soon, empty_soon, empty, overflow, underflow
    );

    modport slave (
        input  re, we, we_count, dat_w_1, dat_w_2, dat_w_3, dat_w_4,
        output dat_r, count, full_soon, empty_soon, empty, overflow, underflow
    );
endinterface

// File: rtl/instr_fifo.sv
// Multi-push (1..4 per cycle), single-pop instruction FIFO with registered, zero-filled read data.
// Define INSTR_FIFO_ERR_EN to enable the sticky overflow/underflow flags and the dropped-push assertion.
module instr_fifo #(
    parameter int LINE  = 22,
    parameter int DEPTH = 32,
    parameter int SOON  = 4
) (
    input  logic        clk,
    input  logic        reset,
    instr_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LINE-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [LINE-1:0] dat_r_q;
    logic [LINE-1:0] dat_w [4];
    logic [CW-1:0]   n;
    logic [CW-1:0]   free;
    logic            push_ok;
    logic            pop_ok;

    assign dat_w[0] = bus.dat_w_1;
    assign dat_w[1] = bus.dat_w_2;
    assign dat_w[2] = bus.dat_w_3;
    assign dat_w[3] = bus.dat_w_4;

    // Acceptance uses the pre-cycle occupancy only; a same-cycle pop is not credited.
    assign n       = CW'(bus.we_count) + CW'(1);
    assign free    = CW'(DEPTH) - count_q;
    assign push_ok = bus.we && (n <= free);
    assign pop_ok  = bus.re && (count_q != '0);

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (i <= int'(bus.we_count)) begin
                    mem[wr_ptr + AW'(i)] <= dat_w[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            dat_r_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(n);
            end
            // Bubbles are driven as zero so the instruction's active bit reads 0.
            if (pop_ok) begin
                dat_r_q <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end else begin
                dat_r_q <= '0;
            end
            count_q <= count_q + (push_ok ? n : CW'(0)) - (pop_ok ? CW'(1) : CW'(0));
        end
    end

    assign bus.dat_r      = dat_r_q;
    assign bus.count      = count_q;
    assign bus.empty      = (count_q == '0);
    assign bus.empty_soon = (32'(count_q) <= 32'(SOON));
    assign bus.full_soon  = (32'(free) < 32'(SOON));

`ifdef INSTR_FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.we && !push_ok) begin
                ovf_q <= 1'b1;
            end
            if (bus.re && !pop_ok) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.we && !push_ok))
                else $warning("instr_fifo: push of %0d dropped at count %0d", n, count_q);
        end
    end
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fifo.sv
// Bench for instr_fifo: directed steps plus random traffic checked against a queue-based model.
module tb_instr_fifo;
    localparam int LINE  = 22;
    localparam int DEPTH = 32;
    localparam int SOON  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_fifo_if #(.LINE(LINE), .DEPTH(DEPTH)) bus();

    instr_fifo #(.LINE(LINE), .DEPTH(DEPTH), .SOON(SOON)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [LINE-1:0] exp_q[$];
    logic [LINE-1:0] exp_dat;
    logic            exp_ovf;
    logic            exp_unf;
    int              checks = 0;
    int              errors = 0;

    function automatic logic [LINE-1:0] rd();
        return LINE'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic check_all();
        int sz;
        sz = exp_q.size();
        chk("dat_r", 32'(bus.dat_r), 32'(exp_dat));
        chk("count", 32'(bus.count), 32'(sz));
        chk("empty", 32'(bus.empty), 32'(sz == 0));
        chk("empty_soon", 32'(bus.empty_soon), 32'(sz <= SOON));
        chk("full_soon", 32'(bus.full_soon), 32'((DEPTH - sz) < SOON));
`ifdef INSTR_FIFO_ERR_EN
        chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
        chk("underflow", 32'(bus.underflow), 32'(exp_unf));
`else
        chk("overflow", 32'(bus.overflow), 32'(0));
        chk("underflow", 32'(bus.underflow), 32'(0));
`endif
    endtask

    task automatic do_reset(input logic w, input logic r);
        bus.we       = w;
        bus.we_count = 2'd3;
        bus.dat_w_1  = rd();
        bus.dat_w_2  = rd();
        bus.dat_w_3  = rd();
        bus.dat_w_4  = rd();
        bus.re       = r;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bus.we  = 1'b0;
        bus.re  = 1'b0;
        exp_q.delete();
        exp_dat = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_all();
    endtask

    task automatic step(input logic w, input logic [1:0] wc, input logic r,
                        input logic [LINE-1:0] d1, input logic [LINE-1:0] d2,
                        input logic [LINE-1:0] d3, input logic [LINE-1:0] d4);
        logic [LINE-1:0] d [4];
        int n;
        int sz;
        d[0] = d1; d[1] = d2; d[2] = d3; d[3] = d4;
        bus.we       = w;
        bus.we_count = wc;
        bus.re       = r;
        bus.dat_w_1  = d1;
        bus.dat_w_2  = d2;
        bus.dat_w_3  = d3;
        bus.dat_w_4  = d4;
        n  = int'(wc) + 1;
        sz = exp_q.size();
        exp_dat = '0;
        if (r) begin
            if (sz > 0) exp_dat = exp_q.pop_front();
            else exp_unf = 1'b1;
        end
        if (w) begin
            if (n <= DEPTH - sz) begin
                for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pop1();
        step(1'b0, 2'd0, 1'b1, rd(), rd(), rd(), rd());
    endtask

    task automatic push(input logic [1:0] wc);
        step(1'b1, wc, 1'b0, rd(), rd(), rd(), rd());
    endtask

    initial begin
        reset        = 1'b1;
        bus.we       = 1'b0;
        bus.re       = 1'b0;
        bus.we_count = 2'd0;
        bus.dat_w_1  = '0;
        bus.dat_w_2  = '0;
        bus.dat_w_3  = '0;
        bus.dat_w_4  = '0;
        exp_ovf      = 1'b0;
        exp_unf      = 1'b0;
        exp_dat      = '0;

        // Reset state
        do_reset(1'b1, 1'b1);
        chk("reset_empty", 32'(bus.empty), 32'd1);

        // Four in one cycle, then five pops: 1,2,3,4,0
        step(1'b1, 2'd3, 1'b0, LINE'(1), LINE'(2), LINE'(3), LINE'(4));
        chk("count_4", 32'(bus.count), 32'd4);
        for (int i = 0; i < 5; i++) pop1();
        chk("pop4_last_zero", 32'(bus.dat_r), 32'd0);
        chk("empty_end", 32'(bus.empty), 32'd1);

        // Fill to DEPTH, hitting 29 on the way
        for (int i = 0; i < 7; i++) push(2'd3);
        chk("count_28", 32'(bus.count), 32'd28);
        push(2'd0);
        chk("full_soon_29", 32'(bus.full_soon), 32'd1);
        push(2'd2);
        chk("count_32", 32'(bus.count), 32'd32);
        step(1'b1, 2'd0, 1'b1, rd(), rd(), rd(), rd());
        chk("reject_count_31", 32'(bus.count), 32'd31);
        push(2'd0);
        chk("accept_count_32", 32'(bus.count), 32'd32);
        for (int i = 0; i < 33; i++) pop1();

        // Push two and pop on an empty FIFO in the same cycle
        step(1'b1, 2'd1, 1'b1, LINE'('hA), LINE'('hB), rd(), rd());
        chk("simul_pop_zero", 32'(bus.dat_r), 32'd0);
        pop1();
        chk("simul_a", 32'(bus.dat_r), 32'hA);
        pop1();
        chk("simul_b", 32'(bus.dat_r), 32'hB);

        // Idle gaps: entry, 0, entry, 0 ...
        push(2'd3);
        chk("empty_soon_4", 32'(bus.empty_soon), 32'd1);
        push(2'd0);
        chk("empty_soon_5", 32'(bus.empty_soon), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'd0, (i % 2) == 0, rd(), rd(), rd(), rd());
        end

        // Random traffic across many pointer wraps
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 45, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 55, rd(), rd(), rd(), rd());
        end
        for (int i = 0; i < 36; i++) pop1();

        // Reset mid-operation with a push and pop pending
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) push(2'd3);
        chk("count_20", 32'(bus.count), 32'd20);
        do_reset(1'b1, 1'b1);
        chk("midreset_count", 32'(bus.count), 32'd0);
        chk("midreset_ovf", 32'(bus.overflow), 32'd0);
        chk("midreset_unf", 32'(bus.underflow), 32'd0);
        pop1();
        chk("midreset_push_dropped", 32'(bus.dat_r), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
